// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing, memory-grid geometry and palette for the
// memory viewer.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FP      = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP      = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FP      = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP      = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [4:0] CELL_W = 5'd20;
  localparam logic [5:0] CELL_H = 6'd60;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COLOR_GRID  = '{r: 8'h40, g: 8'h40, b: 8'h40};
  localparam rgb_t COLOR_ON    = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t COLOR_OFF   = '{r: 8'h00, g: 8'h00, b: 8'h60};
  localparam rgb_t COLOR_BLANK = '{r: 8'h00, g: 8'h00, b: 8'h00};

  function automatic rgb_t cell_color(input logic visible, input logic grid,
                                      input logic bit_on);
    if (!visible) return COLOR_BLANK;
    if (grid) return COLOR_GRID;
    return bit_on ? COLOR_ON : COLOR_OFF;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters, sync generation and the divide-by-2 pixel enable.
// Geometry is overridable so reduced rasters can be exercised quickly.
module vga_timing
  import vga_pkg::*;
#(
  parameter logic [9:0] H_VIS   = H_VISIBLE,
  parameter logic [9:0] H_FRONT = H_FP,
  parameter logic [9:0] H_PULSE = H_SYNC,
  parameter logic [9:0] H_LINE  = H_TOTAL,
  parameter logic [9:0] V_VIS   = V_VISIBLE,
  parameter logic [9:0] V_FRONT = V_FP,
  parameter logic [9:0] V_PULSE = V_SYNC,
  parameter logic [9:0] V_FRAME = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       pix_en,
  output logic       visible,
  output logic       hs,
  output logic       vs
);

  logic h_last;
  logic v_last;

  assign h_last = (h_count == H_LINE - 10'd1);
  assign v_last = (v_count == V_FRAME - 10'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en  <= 1'b0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_last) begin
          h_count <= '0;
          v_count <= v_last ? 10'd0 : v_count + 10'd1;
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

  assign visible = (h_count < H_VIS) && (v_count < V_VIS);
  assign hs = ~((h_count >= H_VIS + H_FRONT) &&
                (h_count <  H_VIS + H_FRONT + H_PULSE));
  assign vs = ~((v_count >= V_VIS + V_FRONT) &&
                (v_count <  V_VIS + V_FRONT + V_PULSE));

endmodule

// File: rtl/vga_memory_display.sv
// Renders the first 32 bytes of data memory as a 32x8 grid of bit cells.
// Memory is sampled once per frame so a frame never shows mixed contents.
module vga_memory_display
  import vga_pkg::*;
#(
  parameter logic [9:0] H_VIS   = H_VISIBLE,
  parameter logic [9:0] H_FRONT = H_FP,
  parameter logic [9:0] H_PULSE = H_SYNC,
  parameter logic [9:0] H_LINE  = H_TOTAL,
  parameter logic [9:0] V_VIS   = V_VISIBLE,
  parameter logic [9:0] V_FRONT = V_FP,
  parameter logic [9:0] V_PULSE = V_SYNC,
  parameter logic [9:0] V_FRAME = V_TOTAL,
  parameter logic [4:0] C_W     = CELL_W,
  parameter logic [5:0] C_H     = CELL_H
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [255:0] memory_first_32_bytes,
  output logic [7:0]   VGA_R,
  output logic [7:0]   VGA_G,
  output logic [7:0]   VGA_B,
  output logic         VGA_HS,
  output logic         VGA_VS,
  output logic         VGA_BLANK_N,
  output logic         VGA_SYNC_N,
  output logic         VGA_CLK
);

  logic [9:0]   h_count;
  logic [9:0]   v_count;
  logic         pix_en;
  logic         visible;
  logic         hs;
  logic         vs;
  logic         line_end;
  logic         frame_end;
  logic [255:0] snap;
  logic [4:0]   h_cell;
  logic [5:0]   col;
  logic [5:0]   v_cell;
  logic [3:0]   row;
  logic [7:0]   bit_sel;
  rgb_t         pix;
  rgb_t         rgb_q;

  vga_timing #(
    .H_VIS  (H_VIS),
    .H_FRONT(H_FRONT),
    .H_PULSE(H_PULSE),
    .H_LINE (H_LINE),
    .V_VIS  (V_VIS),
    .V_FRONT(V_FRONT),
    .V_PULSE(V_PULSE),
    .V_FRAME(V_FRAME)
  ) u_timing (
    .clk    (CLOCK_50),
    .rst    (reset),
    .h_count(h_count),
    .v_count(v_count),
    .pix_en (pix_en),
    .visible(visible),
    .hs     (hs),
    .vs     (vs)
  );

  assign line_end  = (h_count == H_LINE - 10'd1);
  assign frame_end = line_end && (v_count == V_FRAME - 10'd1);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      snap <= '0;
    end else if (pix_en && frame_end) begin
      snap <= memory_first_32_bytes;
    end
  end

  // Cell sub-counters track h_count/C_W and v_count/C_H without dividers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      h_cell <= '0;
      col    <= '0;
      v_cell <= '0;
      row    <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        h_cell <= '0;
        col    <= '0;
        if (frame_end) begin
          v_cell <= '0;
          row    <= '0;
        end else if (v_cell == C_H - 6'd1) begin
          v_cell <= '0;
          row    <= row + 4'd1;
        end else begin
          v_cell <= v_cell + 6'd1;
        end
      end else if (h_cell == C_W - 5'd1) begin
        h_cell <= '0;
        col    <= col + 6'd1;
      end else begin
        h_cell <= h_cell + 5'd1;
      end
    end
  end

  // Byte n sits at snap[255-8n -: 8], so cell (row, col) is bit 255-(32*row+col).
  assign bit_sel = 8'd255 - {row[2:0], col[4:0]};
  assign pix     = cell_color(visible, (h_cell == 5'd0) || (v_cell == 6'd0),
                              snap[bit_sel]);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rgb_q       <= COLOR_BLANK;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pix_en) begin
      rgb_q       <= pix;
      VGA_HS      <= hs;
      VGA_VS      <= vs;
      VGA_BLANK_N <= visible;
    end
  end

  assign VGA_R      = rgb_q.r;
  assign VGA_G      = rgb_q.g;
  assign VGA_B      = rgb_q.b;
  assign VGA_SYNC_N = 1'b0;
  assign VGA_CLK    = ~pix_en;

endmodule

// File: tb/tb_vga_memory_display.sv
// Bench for vga_memory_display: a reduced raster instance for frame-level
// behaviour plus a full 640x480 instance for line timing and palette.
module tb_vga_memory_display;

  localparam int HV = 64, HF = 4, HP = 8, HL = 80;
  localparam int VV = 16, VF = 2, VP = 2, VT = 22;
  localparam int CW = 2, CH = 2;
  localparam int FP = HL * VT;
  localparam logic [26:0] RST_OUT = {2'b11, 1'b0, 24'h000000};
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLUE  = 24'h000060;
  localparam logic [23:0] GRID  = 24'h404040;

  logic         CLOCK_50 = 1'b0;
  logic         reset = 1'b1;
  logic         reset_ref = 1'b1;
  logic [255:0] mem = '0;
  logic [255:0] mem_ref = '0;

  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
  logic [7:0] r_R, r_G, r_B;
  logic       r_hs, r_vs, r_blank, r_sync, r_clk;
  logic [26:0] obs, obs_ref;

  int passed = 0;
  int total = 0;
  int e;
  int e_ref;
  logic [255:0] snaps [0:63];

  vga_memory_display #(
    .H_VIS(10'd64), .H_FRONT(10'd4), .H_PULSE(10'd8), .H_LINE(10'd80),
    .V_VIS(10'd16), .V_FRONT(10'd2), .V_PULSE(10'd2), .V_FRAME(10'd22),
    .C_W(5'd2), .C_H(6'd2)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .memory_first_32_bytes(mem),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
  );

  vga_memory_display ref_dut (
    .CLOCK_50(CLOCK_50), .reset(reset_ref), .memory_first_32_bytes(mem_ref),
    .VGA_R(r_R), .VGA_G(r_G), .VGA_B(r_B),
    .VGA_HS(r_hs), .VGA_VS(r_vs), .VGA_BLANK_N(r_blank),
    .VGA_SYNC_N(r_sync), .VGA_CLK(r_clk)
  );

  assign obs     = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
  assign obs_ref = {r_hs, r_vs, r_blank, r_R, r_G, r_B};

  always #10 CLOCK_50 = ~CLOCK_50;

  // Edges since reset release; memory is captured at each frame boundary.
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      e <= 0;
      snaps[0] <= '0;
    end else begin
      e <= e + 1;
      if ((e + 1) % (2 * FP) == 0 && (e + 1) / (2 * FP) < 64)
        snaps[(e + 1) / (2 * FP)] <= mem;
    end
  end

  always @(posedge CLOCK_50 or posedge reset_ref) begin
    if (reset_ref) e_ref <= 0;
    else e_ref <= e_ref + 1;
  end

  // Output after edge ee shows raster pixel ee/2-1 of the frame's snapshot.
  function automatic logic [26:0] expect_out(input int ee, input int hl, vt, hv, hf,
      hp, vv, vf, vp, cw, ch, input logic use_snaps);
    int q, f, h, v, idx;
    logic [255:0] s;
    logic [7:0] byte_v;
    logic vis, on, hs, vs;
    logic [23:0] rgb;
    if (ee < 2) return RST_OUT;
    q = ee / 2 - 1;
    f = q / (hl * vt);
    h = q % hl;
    v = (q / hl) % vt;
    s = (use_snaps && f < 64) ? snaps[f] : '0;
    hs = !(h >= hv + hf && h < hv + hf + hp);
    vs = !(v >= vv + vf && v < vv + vf + vp);
    vis = (h < hv) && (v < vv);
    rgb = 24'h0;
    if (vis) begin
      idx = (v / ch) * 32 + h / cw;
      byte_v = s[255 - 8 * (idx / 8) -: 8];
      on = byte_v[7 - idx % 8];
      if (h % cw == 0 || v % ch == 0) rgb = GRID;
      else rgb = on ? WHITE : BLUE;
    end
    return {hs, vs, vis, rgb};
  endfunction

  task automatic goto_pix(input int f, input int h, input int v);
    int target, n;
    target = 2 * (f * FP + v * HL + h + 1);
    n = 0;
    while (e < target && n < 9000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (e != target) begin
      total++;
      $display("FAIL goto f=%0d h=%0d v=%0d: at edge %0d, required %0d", f, h, v, e, target);
    end
  endtask

  task automatic test_reset();
    mem = '1;
    #25;
    total++;
    if (obs !== RST_OUT) $display("FAIL reset_outputs: got %h want %h", obs, RST_OUT);
    else passed++;
    total++;
    if (VGA_SYNC_N !== 1'b0 || VGA_CLK !== 1'b1)
      $display("FAIL reset_sync_clk: got %b%b want 01", VGA_SYNC_N, VGA_CLK);
    else passed++;
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    total++;
    if (obs !== RST_OUT || VGA_CLK !== 1'b0)
      $display("FAIL first_edge: got %h clk %b want %h clk 0", obs, VGA_CLK, RST_OUT);
    else passed++;
    @(negedge CLOCK_50);
    total++;
    if (obs !== {3'b111, GRID} || VGA_CLK !== 1'b1)
      $display("FAIL first_pixel: got %h clk %b want %h clk 1", obs, VGA_CLK, {3'b111, GRID});
    else passed++;
    goto_pix(0, 1, 1);
    total++;
    if (obs !== {3'b111, BLUE})
      $display("FAIL frame0_snap_zero: got %h want %h", obs, {3'b111, BLUE});
    else passed++;
  endtask

  task automatic test_timing();
    int mism, bad_lines, vs_low, clk_low, hs_low, bad_k;
    logic [26:0] ex, bad_obs, bad_ex;
    for (int i = 0; i < 8; i++) mem[32 * i +: 32] = $urandom();
    for (int f = 1; f <= 2; f++) begin
      goto_pix(f, 0, 0);
      mism = 0; bad_lines = 0; vs_low = 0; clk_low = 0; hs_low = 0;
      bad_k = 0; bad_obs = '0; bad_ex = '0;
      for (int k = 0; k < FP; k++) begin
        ex = expect_out(e, HL, VT, HV, HF, HP, VV, VF, VP, CW, CH, 1'b1);
        if (obs !== ex) begin
          if (mism == 0) begin bad_k = k; bad_obs = obs; bad_ex = ex; end
          mism++;
        end
        if (VGA_HS === 1'b0) hs_low++;
        if (VGA_VS === 1'b0) vs_low++;
        if (k % HL == HL - 1) begin
          if (hs_low != HP) bad_lines++;
          hs_low = 0;
        end
        if (f == 1 && k == FP / 2)
          for (int i = 0; i < 8; i++) mem[32 * i +: 32] = $urandom();
        @(negedge CLOCK_50);
        if (VGA_CLK === 1'b0) clk_low++;
        @(negedge CLOCK_50);
      end
      total++;
      if (mism != 0)
        $display("FAIL pixel_stream f=%0d: %0d bad, first k=%0d got %h want %h",
                 f, mism, bad_k, bad_obs, bad_ex);
      else passed++;
      total++;
      if (bad_lines != 0) $display("FAIL hs_width f=%0d: %0d lines wrong, want 0", f, bad_lines);
      else passed++;
      total++;
      if (vs_low != VP * HL) $display("FAIL vs_width f=%0d: got %0d want %0d", f, vs_low, VP * HL);
      else passed++;
      total++;
      if (clk_low != FP) $display("FAIL pix_en_count f=%0d: got %0d want %0d", f, clk_low, FP);
      else passed++;
    end
  endtask

  task automatic test_mapping();
    int hs_[5] = '{1, 3, 1, 61, 63};
    int vs_[5] = '{1, 1, 15, 15, 15};
    logic [23:0] want[5] = '{WHITE, BLUE, BLUE, BLUE, WHITE};
    mem = '0;
    mem[255:248] = 8'h80;
    mem[7:0] = 8'h01;
    for (int i = 0; i < 5; i++) begin
      goto_pix(4, hs_[i], vs_[i]);
      total++;
      if (obs !== {3'b111, want[i]})
        $display("FAIL mapping h=%0d v=%0d: got %h want %h", hs_[i], vs_[i], obs, {3'b111, want[i]});
      else passed++;
    end
  endtask

  task automatic test_no_tearing();
    int fs[7] = '{5, 5, 5, 6, 6, 6, 6};
    int hs_[7] = '{0, 1, 63, 1, 2, 1, 63};
    int vs_[7] = '{9, 9, 15, 1, 1, 2, 15};
    logic [23:0] want[7] = '{GRID, BLUE, BLUE, WHITE, GRID, GRID, WHITE};
    mem = '0;
    goto_pix(5, 0, 6);
    mem = '1;
    for (int i = 0; i < 7; i++) begin
      goto_pix(fs[i], hs_[i], vs_[i]);
      total++;
      if (obs !== {3'b111, want[i]})
        $display("FAIL tearing f=%0d h=%0d v=%0d: got %h want %h",
                 fs[i], hs_[i], vs_[i], obs, {3'b111, want[i]});
      else passed++;
    end
  endtask

  task automatic test_blanking();
    logic want_sync;
    goto_pix(7, HV - 1, 3);
    total++;
    if (obs !== {3'b111, WHITE})
      $display("FAIL last_visible: got %h want %h", obs, {3'b111, WHITE});
    else passed++;
    for (int h = HV; h < HL; h++) begin
      goto_pix(7, h, 3);
      want_sync = !(h >= HV + HF && h < HV + HF + HP);
      total++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== 25'h0 || VGA_HS !== want_sync)
        $display("FAIL h_blank h=%0d: got blank/rgb %h hs %b want 0 hs %b",
                 h, {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, VGA_HS, want_sync);
      else passed++;
    end
    for (int v = VV; v < VT; v++) begin
      goto_pix(7, 5, v);
      want_sync = !(v >= VV + VF && v < VV + VF + VP);
      total++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== 25'h0 || VGA_VS !== want_sync)
        $display("FAIL v_blank v=%0d: got blank/rgb %h vs %b want 0 vs %b",
                 v, {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, VGA_VS, want_sync);
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    int vs_low, first_vs;
    goto_pix(8, 10, 12);
    reset = 1'b1;
    #1;
    total++;
    if (obs !== RST_OUT || VGA_CLK !== 1'b1)
      $display("FAIL async_reset: got %h clk %b want %h clk 1", obs, VGA_CLK, RST_OUT);
    else passed++;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    total++;
    if (obs !== RST_OUT) $display("FAIL reset_hold: got %h want %h", obs, RST_OUT);
    else passed++;
    reset = 1'b0;
    goto_pix(0, 1, 1);
    total++;
    if (obs !== {3'b111, BLUE})
      $display("FAIL snap_cleared: got %h want %h", obs, {3'b111, BLUE});
    else passed++;
    vs_low = 0;
    first_vs = -1;
    for (int k = HL + 1; k < FP; k++) begin
      if (VGA_VS === 1'b0) begin
        vs_low++;
        if (first_vs < 0) first_vs = k;
      end
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
    end
    total++;
    if (vs_low != VP * HL || first_vs != (VV + VF) * HL)
      $display("FAIL restart_vs: got %0d low from %0d want %0d from %0d",
               vs_low, first_vs, VP * HL, (VV + VF) * HL);
    else passed++;
    goto_pix(1, 1, 1);
    total++;
    if (obs !== {3'b111, WHITE})
      $display("FAIL restart_load: got %h want %h", obs, {3'b111, WHITE});
    else passed++;
  endtask

  task automatic test_full_geometry();
    int mism, bad_lines, hs_low, clk_low, bad_k;
    logic [26:0] ex, bad_obs, bad_ex;
    @(negedge CLOCK_50);
    reset_ref = 1'b0;
    mism = 0; bad_lines = 0; hs_low = 0; clk_low = 0;
    bad_k = 0; bad_obs = '0; bad_ex = '0;
    for (int k = 0; k < 6 * 800; k++) begin
      @(negedge CLOCK_50);
      if (r_clk === 1'b0) clk_low++;
      @(negedge CLOCK_50);
      ex = expect_out(e_ref, 800, 525, 640, 16, 96, 480, 10, 2, 20, 60, 1'b0);
      if (obs_ref !== ex) begin
        if (mism == 0) begin bad_k = k; bad_obs = obs_ref; bad_ex = ex; end
        mism++;
      end
      if (r_hs === 1'b0) hs_low++;
      if (k % 800 == 799) begin
        if (hs_low != 96) bad_lines++;
        hs_low = 0;
      end
    end
    total++;
    if (mism != 0)
      $display("FAIL full_pixels: %0d bad, first k=%0d got %h want %h", mism, bad_k, bad_obs, bad_ex);
    else passed++;
    total++;
    if (bad_lines != 0) $display("FAIL full_hs_width: %0d lines wrong, want 0", bad_lines);
    else passed++;
    total++;
    if (clk_low != 6 * 800 || r_sync !== 1'b0)
      $display("FAIL full_pix_en: got %0d sync_n %b want %0d sync_n 0", clk_low, r_sync, 6 * 800);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_mapping();
    test_no_tearing();
    test_blanking();
    test_reset_midframe();
    test_full_geometry();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
